regfile_param: RTL and testbench

Parametrised multi-ported register file: 2 combinational read ports, 1 synchronous write port, write-to-read bypass.
Adds a per-register pending-write scoreboard for pipeline hazard detection.
Adds a sequenced bulk-clear engine that zeroes one register per cycle.
Sits between decode (reads, reservations) and writeback (writes) in the CPU datapath.

---
 rtl/regfile_param.sv | 186 ++++++++++++++++++
 tb/tb_regfile_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//
// Purpose:
//   Parametrised register file for the CPU datapath, sitting between decode
//   (reads and reservations) and writeback (writes).
//   - 2 combinational read ports with write-to-read bypass
//   - 1 synchronous write port
//   - per-register pending-write scoreboard for pipeline hazard detection
//   - sequenced bulk-clear engine that zeroes one register per cycle
//
// Ports:
//   clk                    rising-edge system clock
//   rst                    asynchronous reset, active-low (0 = reset)
//   rd_addr1 / rd_data1    read port 1 address / data (combinational)
//   rd_addr2 / rd_data2    read port 2 address / data (combinational)
//   wr_en, wr_addr, wr_data    writeback port; clears the pending bit
//   rsv_en, rsv_addr       reserve strobe; marks a register pending
//   pend1 / pend2          operand on port 1 / 2 has an outstanding write
//   clr_req                start a bulk clear
//   clr_busy               bulk clear in progress (CLEAR or DONE state)
//   clr_done               one-cycle pulse when the bulk clear finishes
//
// Build option:
//   R0_ZERO_EN  when defined, register 0 is hard-wired to zero: it always
//               reads 0 (bypass included), writes to it are dropped, and it
//               can never be reserved. When undefined it is a normal register.
// ---------------------------------------------------------------------------
module regfile_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              pend1,
  output logic              pend2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int NREGS = 2 ** ADDR_W;
  // Index of the last register; the clear counter stops here instead of wrapping.
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

`ifdef R0_ZERO_EN
  localparam logic R0_ZERO = 1'b1;
`else
  localparam logic R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Architectural state
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_d;
  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;

  // Qualified strobes: everything from decode/writeback is dropped while busy
  logic idle_s;
  logic wr_ok_s;
  logic rsv_ok_s;

  assign idle_s   = (state_q == ST_IDLE);
  assign wr_ok_s  = wr_en  & idle_s & ~(R0_ZERO & (wr_addr  == {ADDR_W{1'b0}}));
  assign rsv_ok_s = rsv_en & idle_s & ~(R0_ZERO & (rsv_addr == {ADDR_W{1'b0}}));

  // Read port 1: hard zero for r0 (option), else bypass the in-flight write, else storage
  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    if (R0_ZERO && (rd_addr1 == {ADDR_W{1'b0}})) begin
      rd_data1 = {DATA_W{1'b0}};
    end else if (wr_ok_s && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = regs_q[rd_addr1];
    end
  end

  // Read port 2: same selection as port 1
  always_comb begin
    rd_data2 = regs_q[rd_addr2];
    if (R0_ZERO && (rd_addr2 == {ADDR_W{1'b0}})) begin
      rd_data2 = {DATA_W{1'b0}};
    end else if (wr_ok_s && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
    end else begin
      rd_data2 = regs_q[rd_addr2];
    end
  end

  // An operand being bypassed this cycle is already available, so it is not a hazard.
  assign pend1 = pend_q[rd_addr1] & ~(wr_en & idle_s & (wr_addr == rd_addr1));
  assign pend2 = pend_q[rd_addr2] & ~(wr_en & idle_s & (wr_addr == rd_addr2));

  assign clr_busy = busy_q;
  assign clr_done = done_q;

  // Next-state logic: write/reserve in IDLE, one register zeroed per cycle in CLEAR
  always_comb begin
    regs_d  = regs_q;
    pend_d  = pend_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        regs_d[wr_addr] = wr_ok_s ? wr_data : regs_q[wr_addr];
        pend_d[wr_addr] = pend_q[wr_addr] & ~wr_ok_s;
        // Applied after the write so a same-cycle reservation leaves the bit set.
        pend_d[rsv_addr] = pend_d[rsv_addr] | rsv_ok_s;
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
      end
      ST_CLEAR: begin
        regs_d[cnt_q] = {DATA_W{1'b0}};
        pend_d[cnt_q] = 1'b0;
        if (cnt_q == LAST_IDX) begin
          // Hold the counter at the last index rather than wrapping to 0.
          state_d = ST_DONE;
          done_d  = 1'b1;
          cnt_d   = cnt_q;
        end else begin
          state_d = ST_CLEAR;
          cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State registers with asynchronous active-low reset; reset also aborts a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      pend_q  <= {NREGS{1'b0}};
      state_q <= ST_IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//
// Directed-vector bench for regfile_param. The stimulus process drives inputs
// just after each rising edge and pushes the hand-computed expectations for
// that cycle into a scoreboard queue; a monitor on the falling edge pops and
// compares every expectation whose cycle has arrived.
// ---------------------------------------------------------------------------
module tb_regfile_param;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

`ifdef R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  localparam int K_RD1  = 0;
  localparam int K_RD2  = 1;
  localparam int K_P1   = 2;
  localparam int K_P2   = 3;
  localparam int K_BUSY = 4;
  localparam int K_DONE = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [DW-1:0] rd_data1;
  logic [AW-1:0] rd_addr2 = '0;
  logic [DW-1:0] rd_data2;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic          pend1;
  logic          pend2;
  logic          clr_req = 1'b0;
  logic          clr_busy;
  logic          clr_done;

  regfile_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend1(pend1), .pend2(pend2),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  task automatic expect_v(input int kind, input logic [15:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      K_RD1:   return rd_data1;
      K_RD2:   return rd_data2;
      K_P1:    return {15'd0, pend1};
      K_P2:    return {15'd0, pend2};
      K_BUSY:  return {15'd0, clr_busy};
      K_DONE:  return {15'd0, clr_done};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, then close out the run
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e   = sb_q.pop_front();
      act = observe(e.kind);
      checks++;
      if (e.cyc != cyc || act !== e.val) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=%h expected=%h", e.name, e.cyc, act, e.val);
      end
    end
    if (stim_done) begin
      if (sb_q.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain actual=%0d pending expectations required=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge with strobes deasserted
  task automatic step();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rsv_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    step();
    expect_v(K_BUSY, 16'd0, "rst_busy");
    expect_v(K_DONE, 16'd0, "rst_done");
    step();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      step();
      rd_addr1 = AW'(i);
      rd_addr2 = AW'(NR - 1 - i);
      expect_v(K_RD1, 16'h0000, "reset_rd1");
      expect_v(K_RD2, 16'h0000, "reset_rd2");
      expect_v(K_P1, 16'd0, "reset_p1");
      expect_v(K_P2, 16'd0, "reset_p2");
      expect_v(K_BUSY, 16'd0, "reset_busy");
    end

    // ---- write with bypass, then from storage ----
    step();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    rd_addr1 = 4'd5; rd_addr2 = 4'd5;
    expect_v(K_RD1, 16'hBEEF, "bypass_rd1");
    expect_v(K_RD2, 16'hBEEF, "bypass_rd2");
    step();
    expect_v(K_RD1, 16'hBEEF, "stored_rd1");
    expect_v(K_P1, 16'd0, "stored_p1");

    // ---- reservation, hazard, writeback clears it ----
    step();
    rsv_en = 1'b1; rsv_addr = 4'd3; rd_addr2 = 4'd3; rd_addr1 = 4'd3;
    expect_v(K_P2, 16'd0, "rsv_same_cycle_p2");
    step();
    expect_v(K_P2, 16'd1, "rsv_p2");
    expect_v(K_P1, 16'd1, "rsv_p1");
    step();
    expect_v(K_P2, 16'd1, "rsv_hold_p2");
    step();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    expect_v(K_P2, 16'd0, "wb_bypass_p2");
    expect_v(K_RD2, 16'h1234, "wb_bypass_rd2");
    step();
    expect_v(K_P2, 16'd0, "wb_after_p2");
    expect_v(K_RD2, 16'h1234, "wb_after_rd2");

    // ---- same-cycle reserve and write: reservation wins ----
    step();
    rsv_en = 1'b1; rsv_addr = 4'd7;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0707;
    rd_addr1 = 4'd7;
    expect_v(K_RD1, 16'h0707, "rsvwr_bypass_rd1");
    expect_v(K_P1, 16'd0, "rsvwr_bypass_p1");
    step();
    expect_v(K_RD1, 16'h0707, "rsvwr_rd1");
    expect_v(K_P1, 16'd1, "rsvwr_p1");

    // ---- register 0 behaviour ----
    step();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 4'd0;
    rd_addr1 = 4'd0;
    expect_v(K_RD1, R0 ? 16'h0000 : 16'hFFFF, "r0_bypass_rd1");
    expect_v(K_P1, 16'd0, "r0_bypass_p1");
    step();
    expect_v(K_RD1, R0 ? 16'h0000 : 16'hFFFF, "r0_rd1");
    expect_v(K_P1, R0 ? 16'd0 : 16'd1, "r0_p1");

    // ---- fill all registers, reserve one, then bulk clear ----
    for (int i = 0; i < NR; i++) begin
      step();
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'hA5A5;
    end
    step();
    rsv_en = 1'b1; rsv_addr = 4'd9;
    rd_addr1 = 4'd15; rd_addr2 = 4'd0;
    expect_v(K_RD1, 16'hA5A5, "fill_rd1");
    expect_v(K_RD2, R0 ? 16'h0000 : 16'hA5A5, "fill_rd2");
    step();
    rd_addr1 = 4'd9;
    clr_req = 1'b1;
    expect_v(K_P1, 16'd1, "pre_clear_p1");
    expect_v(K_BUSY, 16'd0, "pre_clear_busy");
    for (int k = 0; k <= 16; k++) begin
      step();
      expect_v(K_BUSY, 16'd1, "clear_busy");
      expect_v(K_DONE, (k == 16) ? 16'd1 : 16'd0, "clear_done");
      if (k == 5) begin
        // regs 0..4 already zeroed, reg 6 not yet; strobes must be dropped
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222;
        rsv_en = 1'b1; rsv_addr = 4'd2;
        clr_req = 1'b1;
        rd_addr1 = 4'd2; rd_addr2 = 4'd6;
        expect_v(K_RD1, 16'h0000, "clear_mid_rd1");
        expect_v(K_RD2, 16'hA5A5, "clear_mid_rd2");
        expect_v(K_P1, 16'd0, "clear_mid_p1");
      end
    end
    step();
    expect_v(K_BUSY, 16'd0, "clear_end_busy");
    expect_v(K_DONE, 16'd0, "clear_end_done");
    for (int i = 0; i < NR; i++) begin
      step();
      rd_addr1 = AW'(i);
      rd_addr2 = AW'(NR - 1 - i);
      expect_v(K_RD1, 16'h0000, "cleared_rd1");
      expect_v(K_RD2, 16'h0000, "cleared_rd2");
      expect_v(K_P1, 16'd0, "cleared_p1");
      expect_v(K_P2, 16'd0, "cleared_p2");
    end

    // ---- async reset aborts a clear at counter 8 ----
    step();
    wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'h1010;
    step();
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 16'h1414;
    step();
    clr_req = 1'b1;
    rd_addr1 = 4'd10; rd_addr2 = 4'd14;
    expect_v(K_RD1, 16'h1010, "abort_pre_rd1");
    expect_v(K_RD2, 16'h1414, "abort_pre_rd2");
    for (int k = 0; k < 8; k++) begin
      step();
      expect_v(K_BUSY, 16'd1, "abort_busy");
    end
    step();
    rst = 1'b0;
    expect_v(K_BUSY, 16'd0, "abort_rst_busy");
    expect_v(K_DONE, 16'd0, "abort_rst_done");
    expect_v(K_RD1, 16'h0000, "abort_rst_rd1");
    expect_v(K_RD2, 16'h0000, "abort_rst_rd2");
    step();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      expect_v(K_DONE, 16'd0, "abort_no_done");
      expect_v(K_BUSY, 16'd0, "abort_idle_busy");
    end

    step();
    step();
    stim_done = 1'b1;
  end

endmodule
